// File: rtl/mem_bridge_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : mem_bridge_if
// Brief  : CPU request/response channel and two-phase bus signals of mem_bridge.
// Rev    : 1.0
// ----------------------------------------------------------------------------
interface mem_bridge_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        bus_rw;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    // Bridge side.
    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, bus_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, bus_rw, bus_addr, bus_wdata
    );

    // CPU and bus-memory side.
    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, bus_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, bus_rw, bus_addr, bus_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_bridge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : mem_bridge
// Brief  : CPU load/store to two-phase word bus bridge; define MEM_BRIDGE_RMW_EN
//          to turn byte/half stores into read-modify-write sequences.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module mem_bridge #(
    parameter logic [11:0] DRAM_HI = 12'h001
) (
    input  logic        sck,
    input  logic        rst,
    mem_bridge_if.slave io
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        X0    = 3'd2,
        X1    = 3'd3,
        RESP  = 3'd4
`ifdef MEM_BRIDGE_RMW_EN
        , RD0 = 3'd5,
        RD1   = 3'd6
`endif
    } state_t;

    state_t      state_q;
    logic        phase_q;
    logic        we_q;
    logic        signed_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;
    logic        bus_rw_q;
    logic [31:0] bus_addr_q;
    logic [31:0] bus_wdata_q;

    logic        w_illegal;
    logic        w_start;
    logic        w_start_we;
    logic        w_start_rmw;
    logic [31:0] w_start_addr;
    logic [31:0] w_start_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] load_d;
`ifdef MEM_BRIDGE_RMW_EN
    logic [1:0]  w_start_size;
    logic [31:0] w_mask;
    logic [31:0] merge_d;
`endif

    always_comb begin
        w_illegal = (io.req_addr[31:20] != DRAM_HI)
                 || (io.req_size == 2'b11)
                 || (io.req_size == 2'b01 && io.req_addr[0])
                 || (io.req_size == 2'b10 && io.req_addr[1:0] != 2'b00);
`ifndef MEM_BRIDGE_RMW_EN
        if (io.req_we && io.req_size != 2'b10) begin
            w_illegal = 1'b1;
        end
`endif
    end

    // The bus sequence starts straight from IDLE when the next cycle is phase 0,
    // otherwise from ALIGN using the latched request.
    always_comb begin
        w_start_we    = (state_q == IDLE) ? io.req_we    : we_q;
        w_start_addr  = (state_q == IDLE) ? io.req_addr  : addr_q;
        w_start_wdata = (state_q == IDLE) ? io.req_wdata : wdata_q;
        w_start       = (state_q == ALIGN)
                     || (state_q == IDLE && io.req_valid && !w_illegal && phase_q);
        w_start_rmw   = 1'b0;
`ifdef MEM_BRIDGE_RMW_EN
        w_start_size  = (state_q == IDLE) ? io.req_size : size_q;
        w_start_rmw   = w_start_we && (w_start_size != 2'b10);
`endif
    end

    always_comb begin
        w_byte = io.bus_rdata[{addr_q[1:0], 3'b000} +: 8];
        w_half = io.bus_rdata[{addr_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_d = {{24{signed_q & w_byte[7]}}, w_byte};
            2'b01:   load_d = {{16{signed_q & w_half[15]}}, w_half};
            default: load_d = io.bus_rdata;
        endcase
`ifdef MEM_BRIDGE_RMW_EN
        w_mask  = (size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
        merge_d = (io.bus_rdata & ~(w_mask << {addr_q[1:0], 3'b000}))
                | ((wdata_q & w_mask) << {addr_q[1:0], 3'b000});
`endif
    end

    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            phase_q      <= 1'b0;
            we_q         <= 1'b0;
            signed_q     <= 1'b0;
            size_q       <= 2'b00;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            bus_rw_q     <= 1'b0;
            bus_addr_q   <= 32'h0;
            bus_wdata_q  <= 32'h0;
        end else begin
            phase_q      <= ~phase_q;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (io.req_valid) begin
                        we_q     <= io.req_we;
                        signed_q <= io.req_signed;
                        size_q   <= io.req_size;
                        addr_q   <= io.req_addr;
                        wdata_q  <= io.req_wdata;
                        if (w_illegal) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'h0;
                        end else if (!phase_q) begin
                            state_q <= ALIGN;
                        end
                    end
                end
                X0: state_q <= X1;
                X1: begin
                    state_q      <= RESP;
                    bus_rw_q     <= 1'b0;
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= we_q ? 32'h0 : load_d;
                end
`ifdef MEM_BRIDGE_RMW_EN
                RD0: state_q <= RD1;
                RD1: begin
                    state_q     <= X0;
                    bus_rw_q    <= 1'b1;
                    bus_wdata_q <= merge_d;
                end
`endif
                RESP: state_q <= IDLE;
                default: ;
            endcase
            if (w_start) begin
                bus_addr_q <= {w_start_addr[31:2], 2'b00};
                bus_rw_q   <= w_start_we && !w_start_rmw;
                if (w_start_we && !w_start_rmw) begin
                    bus_wdata_q <= w_start_wdata;
                end
                state_q <= X0;
`ifdef MEM_BRIDGE_RMW_EN
                if (w_start_rmw) begin
                    state_q <= RD0;
                end
`endif
            end
        end
    end

    assign io.req_ready  = (state_q == IDLE) && !rst;
    assign io.resp_valid = resp_valid_q;
    assign io.resp_err   = resp_err_q;
    assign io.resp_rdata = resp_rdata_q;
    assign io.bus_rw     = bus_rw_q;
    assign io.bus_addr   = bus_addr_q;
    assign io.bus_wdata  = bus_wdata_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_bridge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_mem_bridge
// Brief  : Self-checking bench for mem_bridge with a word-array bus memory model.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module tb_mem_bridge;
    logic sck = 1'b0;
    logic rst = 1'b0;
    always #5 sck = ~sck;

    mem_bridge_if u_if ();

    mem_bridge #(.DRAM_HI(12'h001)) u_dut (
        .sck (sck),
        .rst (rst),
        .io  (u_if)
    );

    logic [31:0] mem [0:255];
    logic        tb_phase;
    logic        pre_we  = 1'b0;
    logic [7:0]  pre_idx = 8'h0;
    logic [31:0] pre_val = 32'h0;
    int          vectors = 0;
    int          miscompares = 0;

    assign u_if.bus_rdata = mem[u_if.bus_addr[9:2]];

    always @(posedge sck or posedge rst) begin
        if (rst) tb_phase <= 1'b0;
        else     tb_phase <= ~tb_phase;
    end

    // Bus memory commits a write at the end of a phase-1 write cycle.
    always @(posedge sck) begin
        if (pre_we)
            mem[pre_idx] <= pre_val;
        else if (!rst && u_if.bus_rw && tb_phase)
            mem[u_if.bus_addr[9:2]] <= u_if.bus_wdata;
    end

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
        logic [31:0] word;
        int          lat;
        int          rw;
    } exp_t;

    function automatic exp_t model(input logic we, input logic [1:0] size, input logic sgn,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic acc_phase, input logic [31:0] word);
        exp_t        e;
        int          nbytes;
        int          off;
        logic [31:0] v;
        nbytes  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        off     = int'(addr[1:0]);
        e.err   = (addr[31:20] != 12'h001) || (size == 2'd3) || (off % nbytes != 0);
`ifndef MEM_BRIDGE_RMW_EN
        if (we && nbytes < 4) e.err = 1'b1;
`endif
        e.rdata = 32'h0;
        e.word  = word;
        e.rw    = 0;
        e.lat   = 1;
        if (!e.err) begin
            e.lat = acc_phase ? 3 : 4;
            if (we) begin
                e.rw = 2;
                for (int b = 0; b < nbytes; b++) e.word[8*(off+b) +: 8] = wdata[8*b +: 8];
                if (nbytes < 4) e.lat = e.lat + 2;
            end else begin
                v = 32'h0;
                for (int b = 0; b < nbytes; b++) v[8*b +: 8] = word[8*(off+b) +: 8];
                if (sgn && v[8*nbytes-1])
                    for (int b = nbytes; b < 4; b++) v[8*b +: 8] = 8'hFF;
                e.rdata = v;
            end
        end
        return e;
    endfunction

    task automatic preload(input logic [7:0] idx, input logic [31:0] val);
        @(negedge sck);
        pre_idx = idx;
        pre_val = val;
        pre_we  = 1'b1;
        @(negedge sck);
        pre_we  = 1'b0;
    endtask

    task automatic drive_req(input logic we, input logic [1:0] size, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int want_phase, input int hold,
                             output logic acc_phase, output logic [31:0] pre_word,
                             output logic rdy, output int lat, output logic err,
                             output logic [31:0] rdata, output int rw,
                             output logic [31:0] waddr, output logic [31:0] wword,
                             output logic extra);
        logic got;
        @(negedge sck);
        if (want_phase >= 0 && tb_phase != want_phase[0]) @(negedge sck);
        acc_phase       = tb_phase;
        pre_word        = mem[addr[9:2]];
        rdy             = u_if.req_ready;
        u_if.req_we     = we;
        u_if.req_size   = size;
        u_if.req_signed = sgn;
        u_if.req_addr   = addr;
        u_if.req_wdata  = wdata;
        u_if.req_valid  = 1'b1;
        @(posedge sck);
        #1;
        if (hold == 0) u_if.req_valid = 1'b0;
        else           u_if.req_addr  = addr ^ 32'h4;
        lat = 0; err = 1'b0; rdata = 32'h0; rw = 0; waddr = 32'h0; wword = 32'h0; got = 1'b0;
        for (int n = 1; n <= 16 && !got; n++) begin
            @(negedge sck);
            if (n == hold) u_if.req_valid = 1'b0;
            if (u_if.bus_rw) begin
                rw++;
                waddr = u_if.bus_addr;
                wword = u_if.bus_wdata;
            end
            if (u_if.resp_valid) begin
                got   = 1'b1;
                lat   = n;
                err   = u_if.resp_err;
                rdata = u_if.resp_rdata;
            end
        end
        u_if.req_valid = 1'b0;
        @(negedge sck);
        extra = u_if.resp_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 256; i++) begin
            @(negedge sck);
            pre_idx = 8'(i);
            pre_val = $urandom;
            pre_we  = 1'b1;
        end
        @(negedge sck);
        pre_we = 1'b0;
        vectors++; if (u_if.req_ready !== 1'b0) begin miscompares++; $display("FAIL reset req_ready: got %0b want 0", u_if.req_ready); end
        vectors++; if (u_if.resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset resp_valid: got %0b want 0", u_if.resp_valid); end
        vectors++; if (u_if.resp_err !== 1'b0) begin miscompares++; $display("FAIL reset resp_err: got %0b want 0", u_if.resp_err); end
        vectors++; if (u_if.resp_rdata !== 32'h0) begin miscompares++; $display("FAIL reset resp_rdata: got %h want 0", u_if.resp_rdata); end
        vectors++; if (u_if.bus_rw !== 1'b0) begin miscompares++; $display("FAIL reset bus_rw: got %0b want 0", u_if.bus_rw); end
        vectors++; if (u_if.bus_addr !== 32'h0) begin miscompares++; $display("FAIL reset bus_addr: got %h want 0", u_if.bus_addr); end
        vectors++; if (u_if.bus_wdata !== 32'h0) begin miscompares++; $display("FAIL reset bus_wdata: got %h want 0", u_if.bus_wdata); end
        rst = 1'b0;
        #1;
        vectors++; if (u_if.req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release req_ready: got %0b want 1", u_if.req_ready); end
    endtask

    task automatic test_word_load();
        logic ap, rdy, err, ex; logic [31:0] pw, rd, wa, ww; int lat, rw;
        preload(8'd2, 32'hDEADBEEF);
        drive_req(1'b0, 2'b10, 1'b0, 32'h00100008, 32'h0, 1, 0, ap, pw, rdy, lat, err, rd, rw, wa, ww, ex);
        vectors++; if (rdy !== 1'b1) begin miscompares++; $display("FAIL word_load ready: got %0b want 1", rdy); end
        vectors++; if (lat != 3) begin miscompares++; $display("FAIL word_load latency: got %0d want 3", lat); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL word_load err: got %0b want 0", err); end
        vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL word_load rdata: got %h want deadbeef", rd); end
        vectors++; if (rw != 0) begin miscompares++; $display("FAIL word_load bus_rw cycles: got %0d want 0", rw); end
        vectors++; if (ex !== 1'b0) begin miscompares++; $display("FAIL word_load pulse width: got %0b want 0", ex); end
    endtask

    task automatic test_word_store();
        logic ap, rdy, err, ex; logic [31:0] pw, rd, wa, ww; int lat, rw;
        drive_req(1'b1, 2'b10, 1'b0, 32'h00100010, 32'h12345678, 0, 0, ap, pw, rdy, lat, err, rd, rw, wa, ww, ex);
        vectors++; if (lat != 4) begin miscompares++; $display("FAIL word_store latency: got %0d want 4", lat); end
        vectors++; if (rw != 2) begin miscompares++; $display("FAIL word_store bus_rw cycles: got %0d want 2", rw); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL word_store err: got %0b want 0", err); end
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL word_store rdata: got %h want 0", rd); end
        vectors++; if (wa !== 32'h00100010) begin miscompares++; $display("FAIL word_store bus_addr: got %h want 00100010", wa); end
        vectors++; if (mem[4] !== 32'h12345678) begin miscompares++; $display("FAIL word_store memory: got %h want 12345678", mem[4]); end
    endtask

    task automatic test_byte_load();
        logic ap, rdy, err, ex; logic [31:0] pw, rd, wa, ww; int lat, rw;
        preload(8'd0, 32'h80FF7F01);
        drive_req(1'b0, 2'b00, 1'b1, 32'h00100003, 32'h0, -1, 0, ap, pw, rdy, lat, err, rd, rw, wa, ww, ex);
        vectors++; if (rd !== 32'hFFFFFF80) begin miscompares++; $display("FAIL byte_load_signed rdata: got %h want ffffff80", rd); end
        drive_req(1'b0, 2'b00, 1'b0, 32'h00100003, 32'h0, -1, 0, ap, pw, rdy, lat, err, rd, rw, wa, ww, ex);
        vectors++; if (rd !== 32'h00000080) begin miscompares++; $display("FAIL byte_load_unsigned rdata: got %h want 00000080", rd); end
    endtask

    task automatic test_errors();
        logic ap, rdy, err, ex; logic [31:0] pw, rd, wa, ww; int lat, rw;
        logic [31:0] addrs [2];
        addrs[0] = 32'h00100002;
        addrs[1] = 32'h00200000;
        for (int k = 0; k < 2; k++) begin
            drive_req(1'b0, 2'b10, 1'b0, addrs[k], 32'h0, -1, 0, ap, pw, rdy, lat, err, rd, rw, wa, ww, ex);
            vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL error[%h] err: got %0b want 1", addrs[k], err); end
            vectors++; if (lat != 1) begin miscompares++; $display("FAIL error[%h] latency: got %0d want 1", addrs[k], lat); end
            vectors++; if (rw != 0) begin miscompares++; $display("FAIL error[%h] bus_rw cycles: got %0d want 0", addrs[k], rw); end
            vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL error[%h] rdata: got %h want 0", addrs[k], rd); end
        end
    endtask

    task automatic test_half_store();
        logic ap, rdy, err, ex; logic [31:0] pw, rd, wa, ww; int lat, rw;
        preload(8'd1, 32'h11223344);
        drive_req(1'b1, 2'b01, 1'b0, 32'h00100006, 32'h0000BEEF, -1, 0, ap, pw, rdy, lat, err, rd, rw, wa, ww, ex);
`ifdef MEM_BRIDGE_RMW_EN
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL half_store err: got %0b want 0", err); end
        vectors++; if (ww !== 32'hBEEF3344) begin miscompares++; $display("FAIL half_store bus_wdata: got %h want beef3344", ww); end
        vectors++; if (rw != 2) begin miscompares++; $display("FAIL half_store bus_rw cycles: got %0d want 2", rw); end
        vectors++; if (mem[1] !== 32'hBEEF3344) begin miscompares++; $display("FAIL half_store memory: got %h want beef3344", mem[1]); end
`else
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL half_store err: got %0b want 1", err); end
        vectors++; if (rw != 0) begin miscompares++; $display("FAIL half_store bus_rw cycles: got %0d want 0", rw); end
        vectors++; if (mem[1] !== 32'h11223344) begin miscompares++; $display("FAIL half_store memory: got %h want 11223344", mem[1]); end
`endif
    endtask

    task automatic test_reset_mid();
        logic ap, rdy, err, ex, seen; logic [31:0] pw, rd, wa, ww; int lat, rw;
        preload(8'd8, 32'h0BADF00D);
        @(negedge sck);
        if (tb_phase != 1'b0) @(negedge sck);
        u_if.req_we = 1'b1; u_if.req_size = 2'b10; u_if.req_signed = 1'b0;
        u_if.req_addr = 32'h00100020; u_if.req_wdata = 32'hA5A5A5A5; u_if.req_valid = 1'b1;
        @(posedge sck);
        #1 u_if.req_valid = 1'b0;
        repeat (3) @(negedge sck);
        vectors++; if (u_if.bus_rw !== 1'b1) begin miscompares++; $display("FAIL reset_mid X1 bus_rw: got %0b want 1", u_if.bus_rw); end
        rst = 1'b1;
        #1;
        vectors++; if (u_if.bus_rw !== 1'b0) begin miscompares++; $display("FAIL reset_mid async bus_rw: got %0b want 0", u_if.bus_rw); end
        vectors++; if (u_if.req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_mid req_ready: got %0b want 0", u_if.req_ready); end
        @(negedge sck);
        rst = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge sck);
            if (u_if.resp_valid) seen = 1'b1;
        end
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL reset_mid stray resp_valid: got %0b want 0", seen); end
        vectors++; if (mem[8] !== 32'h0BADF00D) begin miscompares++; $display("FAIL reset_mid memory: got %h want 0badf00d", mem[8]); end
        drive_req(1'b0, 2'b10, 1'b0, 32'h00100020, 32'h0, -1, 0, ap, pw, rdy, lat, err, rd, rw, wa, ww, ex);
        vectors++; if (err !== 1'b0 || rd !== 32'h0BADF00D) begin miscompares++; $display("FAIL reset_mid next load: got err %0b data %h want err 0 data 0badf00d", err, rd); end
        vectors++; if (lat != (ap ? 3 : 4)) begin miscompares++; $display("FAIL reset_mid next latency: got %0d want %0d", lat, ap ? 3 : 4); end
    endtask

    task automatic test_busy_ignore();
        logic ap, rdy, err, ex; logic [31:0] pw, rd, wa, ww; int lat, rw;
        preload(8'd5, 32'hCAFEF00D);
        preload(8'd4, 32'h55AA55AA);
        drive_req(1'b0, 2'b10, 1'b0, 32'h00100014, 32'h0, -1, 2, ap, pw, rdy, lat, err, rd, rw, wa, ww, ex);
        vectors++; if (rd !== 32'hCAFEF00D) begin miscompares++; $display("FAIL busy_ignore rdata: got %h want cafef00d", rd); end
        vectors++; if (ex !== 1'b0) begin miscompares++; $display("FAIL busy_ignore second pulse: got %0b want 0", ex); end
        @(negedge sck);
        vectors++; if (u_if.resp_valid !== 1'b0) begin miscompares++; $display("FAIL busy_ignore queued request: got %0b want 0", u_if.resp_valid); end
    endtask

    task automatic test_random();
        exp_t        e;
        logic        ap, rdy, err, ex, we, sgn;
        logic [1:0]  size;
        logic [31:0] pw, rd, wa, ww, addr, wdata;
        int          lat, rw;
        for (int i = 0; i < 60; i++) begin
            we    = 1'($urandom_range(0, 1));
            size  = 2'($urandom_range(0, 3));
            sgn   = 1'($urandom_range(0, 1));
            wdata = $urandom;
            addr  = {12'h001, 10'h000, 10'($urandom)};
            if ($urandom_range(0, 9) == 0) addr[31:20] = 12'($urandom_range(2, 4095));
            if ($urandom_range(0, 3) != 0) begin
                if (size == 2'b01) addr[0] = 1'b0;
                if (size == 2'b10) addr[1:0] = 2'b00;
            end
            drive_req(we, size, sgn, addr, wdata, -1, 0, ap, pw, rdy, lat, err, rd, rw, wa, ww, ex);
            e = model(we, size, sgn, addr, wdata, ap, pw);
            vectors++; if (rdy !== 1'b1) begin miscompares++; $display("FAIL rand[%0d] ready: got %0b want 1", i, rdy); end
            vectors++; if (err !== e.err) begin miscompares++; $display("FAIL rand[%0d] err: got %0b want %0b", i, err, e.err); end
            vectors++; if (lat != e.lat) begin miscompares++; $display("FAIL rand[%0d] latency: got %0d want %0d", i, lat, e.lat); end
            vectors++; if (rd !== e.rdata) begin miscompares++; $display("FAIL rand[%0d] rdata: got %h want %h", i, rd, e.rdata); end
            vectors++; if (rw != e.rw) begin miscompares++; $display("FAIL rand[%0d] bus_rw cycles: got %0d want %0d", i, rw, e.rw); end
            vectors++; if (mem[addr[9:2]] !== e.word) begin miscompares++; $display("FAIL rand[%0d] memory: got %h want %h", i, mem[addr[9:2]], e.word); end
            vectors++; if (ex !== 1'b0) begin miscompares++; $display("FAIL rand[%0d] pulse width: got %0b want 0", i, ex); end
            if (rw > 0) begin
                vectors++; if (wa !== {addr[31:2], 2'b00} || ww !== e.word) begin miscompares++; $display("FAIL rand[%0d] bus write: got %h/%h want %h/%h", i, wa, ww, {addr[31:2], 2'b00}, e.word); end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        u_if.req_valid  = 1'b0;
        u_if.req_we     = 1'b0;
        u_if.req_size   = 2'b00;
        u_if.req_signed = 1'b0;
        u_if.req_addr   = 32'h0;
        u_if.req_wdata  = 32'h0;
        test_reset();
        test_word_load();
        test_word_store();
        test_byte_load();
        test_errors();
        test_half_store();
        test_reset_mid();
        test_busy_ignore();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
